dsm_conv_sequencer: RTL

- Shares one delta_sigma_adc modulator between CH input channels by time-multiplexing it.
- Per conversion:
  - picks the next enabled channel round-robin and latches its sample (sample-and-hold);
  - clears the modulator and discards SETTLE cycles of its bitstream;
  - counts ones in the bitstream over 2^OSR_LOG2 cycles;
  - presents the count as a valid/ready result.
- Sits between the channel sources and the modulator. The count is a first-order decimated conversion result.

---
 rtl/dsm_pkg.sv | 24 ++
 rtl/dsm_rr_pick.sv | 32 +++
 rtl/dsm_conv_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dsm_pkg.sv
// Shared types and width helpers for the delta-sigma conversion sequencer.
package dsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_INTEG,
        S_OUTPUT
    } state_t;

    function automatic int ch_w(input int ch);
        return (ch < 2) ? 1 : $clog2(ch);
    endfunction

    function automatic int cnt_w(input int osr_log2);
        return osr_log2 + 1;
    endfunction

    function automatic int n_cycles(input int osr_log2);
        return 1 << osr_log2;
    endfunction

endpackage

// File: rtl/dsm_rr_pick.sv
// Round-robin picker: first requesting channel after last_i, wrapping; last_i itself is checked last.
module dsm_rr_pick
    import dsm_pkg::*;
#(
    parameter  int CH   = 4,
    localparam int CH_W = ch_w(CH)
) (
    input  logic [CH-1:0]   req_i,
    input  logic [CH_W-1:0] last_i,
    output logic            found_o,
    output logic [CH_W-1:0] idx_o
);

    always_comb begin
        int              cand;
        logic [CH_W-1:0] cidx;
        cand    = 0;
        cidx    = '0;
        found_o = 1'b0;
        idx_o   = '0;
        // Walk from farthest to nearest so the nearest hit is the one that sticks.
        for (int k = CH; k >= 1; k--) begin
            cand = (int'(last_i) + k) % CH;
            cidx = cand[CH_W-1:0];
            if (req_i[cidx]) begin
                found_o = 1'b1;
                idx_o   = cidx;
            end
        end
    end

endmodule

// File: rtl/dsm_conv_sequencer.sv
// Time-multiplexes one delta-sigma modulator across CH channels and counts ones
// over 2^OSR_LOG2 cycles per conversion, handing the count out as valid/ready.
module dsm_conv_sequencer
    import dsm_pkg::*;
#(
    parameter  int W        = 16,
    parameter  int CH       = 4,
    parameter  int OSR_LOG2 = 10,
    parameter  int SETTLE   = 16,
    localparam int CH_W     = ch_w(CH),
    localparam int CNT_W    = cnt_w(OSR_LOG2)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic [CH-1:0]     ch_en_i,
    input  logic [CH*W-1:0]   ch_din_i,
    output logic [W-1:0]      mod_din_o,
    output logic              mod_clr_o,
    input  logic              mod_bit_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CH_W-1:0]   res_ch_o,
    output logic [CNT_W-1:0]  res_data_o,
    output logic              busy_o
);

    localparam int N      = n_cycles(OSR_LOG2);
    localparam int PH_MAX = (SETTLE > N) ? SETTLE : N;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [PH_W-1:0] INTEG_LAST  = PH_W'(N - 1);

    state_t             state_q;
    logic [CH_W-1:0]    last_ch_q;
    logic [PH_W-1:0]    phase_q;
    logic [CNT_W-1:0]   ones_q;
    logic [CNT_W-1:0]   ones_d;
    logic [W-1:0]       mod_din_q;
    logic               res_valid_q;
    logic [CH_W-1:0]    res_ch_q;
    logic [CNT_W-1:0]   res_data_q;

    logic               pick_found;
    logic [CH_W-1:0]    pick_idx;
    logic [W-1:0]       sel_din;

    dsm_rr_pick #(.CH(CH)) u_pick (
        .req_i   (ch_en_i),
        .last_i  (last_ch_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign sel_din = ch_din_i[int'(pick_idx)*W +: W];
    // Counter is one bit wider than OSR_LOG2, so an all-ones stream reaches N without wrapping.
    assign ones_d  = ones_q + CNT_W'(mod_bit_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            last_ch_q   <= CH_W'(CH - 1);
            phase_q     <= '0;
            ones_q      <= '0;
            mod_din_q   <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) state_q <= S_SELECT;
                end
                S_SELECT: begin
                    if (run_i && pick_found) begin
                        mod_din_q <= sel_din;
                        res_ch_q  <= pick_idx;
                        last_ch_q <= pick_idx;
                        phase_q   <= '0;
                        ones_q    <= '0;
                        state_q   <= (SETTLE == 0) ? S_INTEG : S_SETTLE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (!run_i) begin
                        state_q <= S_IDLE;
                    end else if (phase_q == SETTLE_LAST) begin
                        phase_q <= '0;
                        state_q <= S_INTEG;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                S_INTEG: begin
                    if (!run_i) begin
                        state_q <= S_IDLE;
                    end else if (phase_q == INTEG_LAST) begin
                        res_data_q  <= ones_d;
                        res_valid_q <= 1'b1;
                        state_q     <= S_OUTPUT;
                    end else begin
                        ones_q  <= ones_d;
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= run_i ? S_SELECT : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mod_din_o   = mod_din_q;
    assign mod_clr_o   = (state_q == S_IDLE) || (state_q == S_SELECT);
    assign res_valid_o = res_valid_q;
    assign res_ch_o    = res_ch_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
